// File: rtl/bus_arbiter_reg_if.sv
// Bus arbiter handshake bundle: source requests/data in,
// registered bus value, grant and conflict status out.
interface bus_arbiter_reg_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 25,
    parameter int CNT_W   = 8
);
    logic [NUM_SRC*WIDTH-1:0] src_data;
    logic [NUM_SRC-1:0]       src_out;
    logic                     clr_err;
    logic [WIDTH-1:0]         bus_out;
    logic                     bus_valid;
    logic [NUM_SRC-1:0]       grant;
    logic                     conflict;
    logic                     conflict_sticky;
    logic [CNT_W-1:0]         conflict_count;

    modport master (
        output src_data, src_out, clr_err,
        input  bus_out, bus_valid, grant,
        input  conflict, conflict_sticky, conflict_count
    );

    modport slave (
        input  src_data, src_out, clr_err,
        output bus_out, bus_valid, grant,
        output conflict, conflict_sticky, conflict_count
    );
endinterface

// File: rtl/bus_arbiter_reg.sv
// Registered CPU bus multiplexer: lowest-index source wins,
// with one-hot grant and multi-driver conflict tracking.
module bus_arbiter_reg #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 25,
    parameter bit HOLD    = 1'b1,
    parameter int CNT_W   = 8
) (
    input logic               clock,
    input logic               clear,
    bus_arbiter_reg_if.slave  bus
);
    logic [NUM_SRC-1:0] win;
    logic [WIDTH-1:0]   sel;
    logic               any;
    logic               multi;

    // x & -x isolates the lowest set request bit
    assign win   = bus.src_out & (~bus.src_out + NUM_SRC'(1));
    assign any   = |bus.src_out;
    assign multi = |(bus.src_out & (bus.src_out - NUM_SRC'(1)));

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (win[i]) sel = sel | bus.src_data[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            bus.bus_out         <= '0;
            bus.bus_valid       <= 1'b0;
            bus.grant           <= '0;
            bus.conflict        <= 1'b0;
            bus.conflict_sticky <= 1'b0;
            bus.conflict_count  <= '0;
        end else begin
            bus.bus_valid <= any;
            bus.grant     <= win;
            if (any) begin
                bus.bus_out <= sel;
            end else if (!HOLD) begin
                bus.bus_out <= '0;
            end
            bus.conflict <= multi;
            if (multi) begin
                bus.conflict_sticky <= 1'b1;
                if (bus.clr_err) begin
                    bus.conflict_count <= CNT_W'(1);
                end else if (bus.conflict_count != '1) begin
                    bus.conflict_count <= bus.conflict_count + CNT_W'(1);
                end
            end else if (bus.clr_err) begin
                bus.conflict_sticky <= 1'b0;
                bus.conflict_count  <= '0;
            end
        end
    end
endmodule
